// File: rtl/irq_sequencer_pkg.sv
// Shared constants and state encoding for the interrupt sequencer, the PC path
// and the return stack.
package irq_sequencer_pkg;

  localparam int unsigned PcWidth    = 10;
  localparam int unsigned StackDepth = 8;

  localparam logic [PcWidth-1:0] VecBaseDefault  = 10'h3C0;
  localparam int unsigned        VecShiftDefault = 2;

  typedef enum logic {
    ST_IDLE,
    ST_SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [2:0]   id
);

  always_comb begin
    any = |req;
    id  = '0;
    // Walk downward so the lowest set index is written last.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: edge-latched requests, fixed priority, single-level entry
// at instruction boundaries with return-stack push/pop.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int unsigned      NIRQ      = 4,
  parameter int unsigned      PCW       = PcWidth,
  parameter logic [PCW-1:0]   VEC_BASE  = VecBaseDefault,
  parameter int unsigned      VEC_SHIFT = VecShiftDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  input  logic            ei,
  input  logic            di,
  input  logic            reti,
  input  logic            boundary,
  input  logic            stack_full,
  input  logic [PCW-1:0]  pc_next,
  output logic            take_int,
  output logic [PCW-1:0]  vec_pc,
  output logic            push,
  output logic [PCW-1:0]  push_data,
  output logic            pop,
  output logic            in_service,
  output logic [2:0]      active_id,
  output logic [NIRQ-1:0] pending,
  output logic            gie,
  output logic            reti_err
);

  irq_state_e      state_q, state_d;
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q;
  logic            gie_q, gie_d;
  logic [2:0]      active_id_q;
  logic            reti_err_q;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr;
  logic            sel_any;
  logic [2:0]      sel_id;
  logic [PCW-1:0]  sel_ext;

  assign rise     = irq & ~irq_prev_q;
  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .N (NIRQ)
  ) u_prio (
    .req (eligible),
    .any (sel_any),
    .id  (sel_id)
  );

  assign sel_ext = PCW'(sel_id);
  assign vec_pc  = VEC_BASE + (sel_ext << VEC_SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (take_int) state_d = ST_SERVICE;
      ST_SERVICE: if (reti)     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs; reset gates the strobes so an aborted handler never pops.
  always_comb begin
    take_int   = 1'b0;
    pop        = 1'b0;
    in_service = 1'b0;
    unique case (state_q)
      ST_IDLE:    take_int = ~reset & gie_q & sel_any & boundary & ~stack_full;
      ST_SERVICE: begin
        pop        = ~reset & reti;
        in_service = 1'b1;
      end
      default: ;
    endcase
  end

  assign push      = take_int;
  assign push_data = pc_next;

  always_comb begin
    clr       = take_int ? (NIRQ'(1) << sel_id) : '0;
    // A same-cycle rise overrides the clear on entry.
    pending_d = (pending_q & ~clr) | rise;

    gie_d = gie_q;
    if (state_q == ST_IDLE) begin
      if (ei)       gie_d = 1'b1;
      if (di)       gie_d = 1'b0;
      if (take_int) gie_d = 1'b0;
    end else if (reti) begin
      gie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    irq_prev_q <= irq;
    if (reset) begin
      pending_q   <= '0;
      mask_q      <= '0;
      gie_q       <= 1'b0;
      active_id_q <= '0;
      reti_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      gie_q     <= gie_d;
      if (mask_we)  mask_q      <= mask_wd;
      if (take_int) active_id_q <= sel_id;
      if (reti && state_q == ST_IDLE) reti_err_q <= 1'b1;
    end
  end

  assign pending   = pending_q;
  assign gie       = gie_q;
  assign active_id = active_id_q;
  assign reti_err  = reti_err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry, priority, stack-full blocking,
// RETI handling, ei/di precedence and reset abort.
module tb_irq_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       ei, di, reti, boundary, stack_full;
  logic [9:0] pc_next;
  logic       take_int, push, pop, in_service, gie, reti_err;
  logic [9:0] vec_pc, push_data;
  logic [2:0] active_id;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;

  irq_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .ei         (ei),
    .di         (di),
    .reti       (reti),
    .boundary   (boundary),
    .stack_full (stack_full),
    .pc_next    (pc_next),
    .take_int   (take_int),
    .vec_pc     (vec_pc),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .in_service (in_service),
    .active_id  (active_id),
    .pending    (pending),
    .gie        (gie),
    .reti_err   (reti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fresh start: reset, then gie=1 and mask=F with no pending requests.
  task automatic do_init;
    reset = 1'b1; irq = 4'h0; ei = 1'b0; di = 1'b0; reti = 1'b0;
    boundary = 1'b0; stack_full = 1'b0; mask_we = 1'b0; mask_wd = 4'h0;
    tick;
    reset = 1'b0; ei = 1'b1; mask_we = 1'b1; mask_wd = 4'hF;
    tick;
    ei = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = 4'b0010; mask_we = 1'b0; mask_wd = 4'h0;
    ei = 1'b0; di = 1'b0; reti = 1'b0; boundary = 1'b0; stack_full = 1'b0;
    pc_next = 10'h000;

    // Reset with irq[1] held high
    tick; tick;
    chk("rst_in_service", 16'(in_service), 16'h0);
    chk("rst_gie", 16'(gie), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_active_id", 16'(active_id), 16'h0);
    chk("rst_reti_err", 16'(reti_err), 16'h0);
    chk("rst_take_int", 16'(take_int), 16'h0);
    reset = 1'b0; ei = 1'b1; mask_we = 1'b1; mask_wd = 4'hF;
    tick;
    ei = 1'b0; mask_we = 1'b0; boundary = 1'b1;
    #1;
    chk("held_gie", 16'(gie), 16'h1);
    chk("held_pending", 16'(pending), 16'h0);
    chk("held_no_take", 16'(take_int), 16'h0);
    boundary = 1'b0; irq = 4'b0000;
    tick;
    irq = 4'b0010;
    tick;
    chk("rearm_pending", 16'(pending), 16'h2);

    // Single source entry and return
    do_init;
    irq = 4'b0100;
    tick;
    chk("t2_pending", 16'(pending), 16'h4);
    boundary = 1'b1; pc_next = 10'h045;
    #1;
    chk("t2_take_int", 16'(take_int), 16'h1);
    chk("t2_push", 16'(push), 16'h1);
    chk("t2_vec_pc", 16'(vec_pc), 16'h3C8);
    chk("t2_push_data", 16'(push_data), 16'h045);
    chk("t2_pop", 16'(pop), 16'h0);
    tick;
    boundary = 1'b0;
    chk("t2_in_service", 16'(in_service), 16'h1);
    chk("t2_active_id", 16'(active_id), 16'h2);
    chk("t2_gie", 16'(gie), 16'h0);
    chk("t2_pending_clr", 16'(pending), 16'h0);
    ei = 1'b1;
    tick;
    ei = 1'b0;
    chk("t2_ei_ignored", 16'(gie), 16'h0);
    reti = 1'b1;
    #1;
    chk("t2_pop", 16'(pop), 16'h1);
    tick;
    reti = 1'b0;
    chk("t2_ret_in_service", 16'(in_service), 16'h0);
    chk("t2_ret_gie", 16'(gie), 16'h1);
    chk("t2_ret_active_id", 16'(active_id), 16'h2);

    // Two sources rise together: lowest index first, one per handler
    do_init;
    irq = 4'b1010;
    tick;
    chk("t3_pending", 16'(pending), 16'hA);
    boundary = 1'b1; pc_next = 10'h100;
    #1;
    chk("t3_take1", 16'(take_int), 16'h1);
    chk("t3_vec1", 16'(vec_pc), 16'h3C4);
    tick;
    boundary = 1'b0;
    chk("t3_active1", 16'(active_id), 16'h1);
    chk("t3_pending1", 16'(pending), 16'h8);
    reti = 1'b1; boundary = 1'b1;
    #1;
    chk("t3_pop", 16'(pop), 16'h1);
    chk("t3_no_take_in_svc", 16'(take_int), 16'h0);
    tick;
    reti = 1'b0;
    chk("t3_gie", 16'(gie), 16'h1);
    chk("t3_take2", 16'(take_int), 16'h1);
    chk("t3_vec2", 16'(vec_pc), 16'h3CC);
    tick;
    boundary = 1'b0;
    chk("t3_active2", 16'(active_id), 16'h3);
    chk("t3_pending2", 16'(pending), 16'h0);

    // Stack full blocks entry across three boundaries
    do_init;
    irq = 4'b0001;
    tick;
    stack_full = 1'b1; boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_blocked", 16'(take_int), 16'h0);
      tick;
    end
    chk("t4_still_pending", 16'(pending), 16'h1);
    stack_full = 1'b0;
    #1;
    chk("t4_take", 16'(take_int), 16'h1);
    chk("t4_vec", 16'(vec_pc), 16'h3C0);
    tick;
    boundary = 1'b0;
    chk("t4_in_service", 16'(in_service), 16'h1);

    // Reset during service aborts without pop
    reset = 1'b1; reti = 1'b1;
    #1;
    chk("t6_pop_in_reset", 16'(pop), 16'h0);
    tick;
    reset = 1'b0; reti = 1'b0;
    chk("t6_in_service", 16'(in_service), 16'h0);
    chk("t6_gie", 16'(gie), 16'h0);
    chk("t6_pending", 16'(pending), 16'h0);
    irq = 4'b0000;
    tick;
    irq = 4'b0001; ei = 1'b1;
    tick;
    ei = 1'b0; boundary = 1'b1;
    #1;
    chk("t6_masked_pending", 16'(pending), 16'h1);
    chk("t6_mask_cleared", 16'(take_int), 16'h0);
    mask_we = 1'b1; mask_wd = 4'h1;
    #1;
    chk("t6_mask_not_yet", 16'(take_int), 16'h0);
    tick;
    mask_we = 1'b0;
    chk("t6_unmasked_take", 16'(take_int), 16'h1);
    boundary = 1'b0;

    // RETI in idle and ei/di together
    do_init;
    reti = 1'b1;
    #1;
    chk("t5_pop_idle", 16'(pop), 16'h0);
    tick;
    reti = 1'b0;
    chk("t5_reti_err", 16'(reti_err), 16'h1);
    chk("t5_state_idle", 16'(in_service), 16'h0);
    tick; tick;
    chk("t5_reti_err_sticky", 16'(reti_err), 16'h1);
    ei = 1'b1; di = 1'b1;
    tick;
    ei = 1'b0; di = 1'b0;
    chk("t5_di_wins", 16'(gie), 16'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_reti_err_rst", 16'(reti_err), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
